// File: rtl/cpack_pkg.sv
// rtl/cpack_pkg.sv - code types and helpers shared by the cpack compressor and decoder
package cpack_pkg;

    localparam int CPACK_WORD_W = 32;

    typedef enum logic [2:0] {
        ZZZZ = 3'd0,
        XXXX = 3'd1,
        MMMM = 3'd2,
        MMXX = 3'd3,
        ZZZX = 3'd4,
        MMMX = 3'd5
    } cpack_code_e;

    // Codes carrying a non-trivial literal become new dictionary entries
    function automatic logic code_pushes(input logic [2:0] code);
        return (code == XXXX) || (code == MMXX) || (code == MMMX);
    endfunction

    function automatic logic code_is_match(input logic [2:0] code);
        return (code == MMMM) || (code == MMXX) || (code == MMMX);
    endfunction

endpackage

// File: rtl/cpack_dict_decoder_if.sv
// rtl/cpack_dict_decoder_if.sv - code input and word output handshakes of the dictionary decoder
interface cpack_dict_decoder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 4
);
    logic                  i_valid;
    logic                  o_ready;
    logic [2:0]            i_code;
    logic [IDX_W-1:0]      i_idx;
    logic [DATA_WIDTH-1:0] i_lit;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_wrap;

    modport slave (
        input  i_valid, i_code, i_idx, i_lit, i_ready,
        output o_ready, o_valid, o_data, o_wrap
    );

    modport master (
        output i_valid, i_code, i_idx, i_lit, i_ready,
        input  o_ready, o_valid, o_data, o_wrap
    );
endinterface

// File: rtl/cpack_dict_regfile.sv
// rtl/cpack_dict_regfile.sv - dictionary storage, one synchronous write port and one combinational read port
module cpack_dict_regfile #(
    parameter int DATA_WIDTH   = 32,
    parameter int DICT_ENTRIES = 16,
    parameter int IDX_W        = $clog2(DICT_ENTRIES)
) (
    input  logic                  i_clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    // No reset: a legal stream never reads an entry before writing it
    logic [DATA_WIDTH-1:0] mem [DICT_ENTRIES];

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/cpack_dict_decoder.sv
// rtl/cpack_dict_decoder.sv - FIFO-dictionary word reconstruction; CPACK_DICT_CHK_EN adds sticky o_err
module cpack_dict_decoder
    import cpack_pkg::*;
#(
    parameter int DATA_WIDTH   = CPACK_WORD_W,
    parameter int DICT_ENTRIES = 16,
    parameter int IDX_W        = $clog2(DICT_ENTRIES)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_flush,
    cpack_dict_decoder_if.slave bus
`ifdef CPACK_DICT_CHK_EN
    ,
    output logic o_err
`endif
);
    logic                  accept;
    logic                  push_en;
    logic [DATA_WIDTH-1:0] dict_rd;
    logic [DATA_WIDTH-1:0] word;
    logic [IDX_W-1:0]      wr_ptr;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  wrap_q;

    assign bus.o_ready = !valid_q || bus.i_ready;
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_wrap  = wrap_q;

    assign accept  = bus.i_valid && bus.o_ready;
    // A flush in the same cycle drops the push so both sides restart from entry 0
    assign push_en = accept && code_pushes(bus.i_code) && !i_flush;

    cpack_dict_regfile #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DICT_ENTRIES(DICT_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_regfile (
        .i_clk (i_clk),
        .we    (push_en),
        .waddr (wr_ptr),
        .wdata (word),
        .raddr (bus.i_idx),
        .rdata (dict_rd)
    );

    always_comb begin
        word = '0;
        case (bus.i_code)
            ZZZZ:    word = '0;
            XXXX:    word = bus.i_lit;
            MMMM:    word = dict_rd;
            MMXX:    word = {dict_rd[31:16], bus.i_lit[15:0]};
            ZZZX:    word = DATA_WIDTH'(bus.i_lit[7:0]);
            MMMX:    word = {dict_rd[31:8], bus.i_lit[7:0]};
            default: word = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            wrap_q  <= 1'b0;
            wr_ptr  <= '0;
        end else begin
            wrap_q <= push_en && (wr_ptr == IDX_W'(DICT_ENTRIES - 1));
            if (accept) begin
                valid_q <= 1'b1;
                data_q  <= word;
            end else if (bus.i_ready) begin
                valid_q <= 1'b0;
            end
            if (i_flush) begin
                wr_ptr <= '0;
            end else if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

`ifdef CPACK_DICT_CHK_EN
    logic [IDX_W:0] fill_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fill_cnt <= '0;
            o_err    <= 1'b0;
        end else if (i_flush) begin
            fill_cnt <= '0;
            o_err    <= 1'b0;
        end else begin
            if (push_en && (fill_cnt != (IDX_W+1)'(DICT_ENTRIES))) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (accept && code_is_match(bus.i_code) && ({1'b0, bus.i_idx} >= fill_cnt)) begin
                o_err <= 1'b1;
            end
        end
    end
`endif
endmodule
